// File: rtl/yasac_io_pkg.sv
// Shared defines for the YASAC I/O port controller (yasac_io_defs):
// default geometry and the status-register offsets above the input ports.
package yasac_io_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_N_OUT = 8;
  localparam int DEF_N_IN  = 8;
  localparam int DEF_AW    = 5;

  // Offsets relative to N_OUT + N_IN (first address past the input ports).
  localparam int FLG_OFS = 0;
  localparam int MSK_OFS = 1;

endpackage

// File: rtl/yasac_io_if.sv
// Registered read/write bus between the data unit and the port controller.
interface yasac_io_if #(
  parameter int AW = 5,
  parameter int W  = 8
);
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata;
  logic          wr;
  logic          rd;
  logic [W-1:0]  rdata;
  logic          rvalid;

  modport master (output addr, wdata, wr, rd, input rdata, rvalid);
  modport slave  (input addr, wdata, wr, rd, output rdata, rvalid);
endinterface

// File: rtl/yasac_io_sync.sv
// One input port: 2-flop synchroniser, previous-value register and change compare.
module yasac_io_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         chg
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic [W-1:0] prev;

  // Synchroniser pipeline followed by the last-seen value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the old value of
      // the previous one; blocking here would collapse the pipeline to one flop.
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign dout = sync2;
  assign chg  = en && (sync2 != prev);

endmodule

// File: rtl/yasac_io.sv
// Parametrised I/O port bank: output registers, synchronised inputs,
// change flags with write-1-to-clear / read-to-clear, mask and irq.
module yasac_io
  import yasac_io_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N_OUT = DEF_N_OUT,
  parameter int N_IN  = DEF_N_IN,   // N_IN <= W
  parameter int AW    = DEF_AW      // 2**AW >= N_OUT + N_IN + 2
) (
  input  logic               clk,
  input  logic               reset,
  yasac_io_if.slave          bus,
  output logic [N_OUT*W-1:0] port_out,
  input  logic [N_IN*W-1:0]  port_in,
  output logic               irq
);

  localparam logic [AW-1:0] FLG_A = AW'(N_OUT + N_IN + FLG_OFS);
  localparam logic [AW-1:0] MSK_A = AW'(N_OUT + N_IN + MSK_OFS);

  logic [W-1:0]    out_q  [N_OUT];
  logic [W-1:0]    in_val [N_IN];
  logic [N_IN-1:0] chg;
  logic [N_IN-1:0] flags;
  logic [N_IN-1:0] mask;
  logic [N_IN-1:0] flg_clr;
  logic [1:0]      warm;
  logic            warm_done;
  logic [W-1:0]    rd_mux;
  logic            wr_flg;
  logic            rd_flg;

  // Warm-up counter: gates change detection until the synchronisers are full.
  always_ff @(posedge clk) begin
    if (reset)              warm <= 2'd0;
    else if (warm != 2'd3)  warm <= warm + 2'd1;
  end

  assign warm_done = (warm == 2'd3);

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    yasac_io_sync #(.W(W)) u_sync (
      .clk   (clk),
      .reset (reset),
      .en    (warm_done),
      .din   (port_in[i*W +: W]),
      .dout  (in_val[i]),
      .chg   (chg[i])
    );
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign port_out[k*W +: W] = out_q[k];
  end

  // Output registers; the write lands on the edge that samples wr.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this register array drives live output pins, so every entry is
      // reset explicitly; a storage-only RAM would normally be left unreset.
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
    end else if (bus.wr) begin
      for (int k = 0; k < N_OUT; k++)
        if (bus.addr == AW'(k)) out_q[k] <= bus.wdata;
    end
  end

  assign wr_flg  = bus.wr && (bus.addr == FLG_A);
  assign rd_flg  = bus.rd && (bus.addr == FLG_A);
  // Reading clears exactly the bits returned; W1C clears the written ones.
  assign flg_clr = (wr_flg ? bus.wdata[N_IN-1:0] : '0) | (rd_flg ? flags : '0);

  // Change flags: a new change on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else       flags <= (flags & ~flg_clr) | chg;
  end

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset)                               mask <= '0;
    else if (bus.wr && (bus.addr == MSK_A))  mask <= bus.wdata[N_IN-1:0];
  end

  // Read mux over the whole address map; pre-write values are returned.
  always_comb begin
    // NOTE: default first so no path through the decode leaves rd_mux
    // unassigned, which would otherwise infer a latch.
    rd_mux = '0;
    for (int k = 0; k < N_OUT; k++)
      if (bus.addr == AW'(k)) rd_mux = out_q[k];
    for (int i = 0; i < N_IN; i++)
      if (bus.addr == AW'(N_OUT + i)) rd_mux = in_val[i];
    if (bus.addr == FLG_A) rd_mux[N_IN-1:0] = flags;
    if (bus.addr == MSK_A) rd_mux[N_IN-1:0] = mask;
  end

  // Registered read port: one result per sampled rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= bus.rd;
      if (bus.rd) bus.rdata <= rd_mux;
    end
  end

  // Interrupt request from the registered flags.
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(flags & mask);
  end

endmodule

// File: tb/tb_yasac_io.sv
// Self-checking bench for yasac_io: directed scenarios followed by random
// bus/input traffic, all read data checked through a scoreboard queue.
module tb_yasac_io;

  localparam int W = 8, N_OUT = 8, N_IN = 8, AW = 5;
  localparam int FLG = N_OUT + N_IN;
  localparam int MSK = FLG + 1;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_OUT*W-1:0] port_out;
  logic [N_IN*W-1:0]  port_in;
  logic               irq;

  yasac_io_if #(.AW(AW), .W(W)) bus ();

  yasac_io #(.W(W), .N_OUT(N_OUT), .N_IN(N_IN), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .port_out (port_out),
    .port_in  (port_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: behaviour from the register map and edge counts.
  logic [W-1:0]       m_out [N_OUT];
  logic [N_IN-1:0]    m_flags, m_mask;
  logic [N_IN*W-1:0]  hist [3];   // port_in sampled 1, 2, 3 edges ago
  int                 m_n;        // edges since reset released
  logic               exp_rv, exp_irq, started = 1'b0;
  logic [W-1:0]       exp_q [$];

  always @(posedge clk) begin : model
    logic [W-1:0]    rv;
    logic [N_IN-1:0] set, clr;
    int              a;
    started = 1'b1;
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
      m_flags = '0; m_mask = '0; m_n = 0;
      for (int j = 0; j < 3; j++) hist[j] = '0;
      exp_rv = 1'b0; exp_irq = 1'b0;
    end else begin
      a  = int'(bus.addr);
      m_n++;
      rv = '0;
      if (a < N_OUT)             rv = m_out[a];
      else if (a < N_OUT + N_IN) rv = hist[1][(a - N_OUT)*W +: W];
      else if (a == FLG)         rv = m_flags;
      else if (a == MSK)         rv = m_mask;
      if (bus.rd) exp_q.push_back(rv);
      exp_rv  = bus.rd;
      exp_irq = |(m_flags & m_mask);
      set = '0;
      for (int i = 0; i < N_IN; i++)
        if (m_n >= 4 && hist[1][i*W +: W] != hist[2][i*W +: W]) set[i] = 1'b1;
      clr = ((bus.wr && a == FLG) ? bus.wdata : '0) | ((bus.rd && a == FLG) ? m_flags : '0);
      if (bus.wr && a < N_OUT) m_out[a] = bus.wdata;
      if (bus.wr && a == MSK)  m_mask = bus.wdata;
      m_flags = (m_flags & ~clr) | set;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = port_in;
    end
  end

  // Monitor: compares outputs each cycle and pops the scoreboard on rvalid.
  always @(negedge clk) begin : monitor
    logic [N_OUT*W-1:0] eo;
    if (started) begin
      for (int k = 0; k < N_OUT; k++) eo[k*W +: W] = m_out[k];
      check("rvalid", 64'(bus.rvalid), 64'(exp_rv));
      check("irq", 64'(irq), 64'(exp_irq));
      check("port_out", 64'(port_out), 64'(eo));
      if (bus.rvalid === 1'b1) begin
        if (exp_q.size() == 0) check("sb_unexpected_rvalid", 64'd1, 64'd0);
        else check("sb_rdata", 64'(bus.rdata), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_wr(input int a, input logic [W-1:0] d);
    bus.addr = AW'(a); bus.wdata = d; bus.wr = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0;
  endtask

  task automatic do_rd_chk(input string name, input int a, input logic [W-1:0] exp);
    bus.addr = AW'(a); bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    check({name, "_rvalid"}, 64'(bus.rvalid), 64'd1);
    check(name, 64'(bus.rdata), 64'(exp));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.addr = '0; bus.wdata = '0; bus.wr = 1'b0; bus.rd = 1'b0;
    reset   = 1'b1;
    port_in = {N_IN{8'hA5}};

    // Reset with constant non-zero inputs: no flag may ever set.
    idle(2);
    reset = 1'b0;
    check("rst_port_out", 64'(port_out), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    idle(10);
    do_rd_chk("rst_flg", FLG, 8'h00);

    // Drop inputs to zero, let the flags from that settle, then clear them.
    port_in = '0;
    idle(5);
    do_wr(FLG, 8'hFF);
    do_rd_chk("flg_cleared", FLG, 8'h00);

    // Output register write/read and an unmapped address.
    do_wr(2, 8'h3C);
    check("port_out_2", 64'(port_out[23:16]), 64'h3C);
    do_rd_chk("rd_out2", 2, 8'h3C);
    do_rd_chk("rd_unmapped", 31, 8'h00);

    // Change detect on input 3: 0x00 -> 0x7F.
    port_in[31:24] = 8'h7F;
    do_rd_chk("in3_e1", N_OUT + 3, 8'h00);
    do_rd_chk("in3_e2", N_OUT + 3, 8'h00);
    do_rd_chk("in3_e3", N_OUT + 3, 8'h7F);
    do_rd_chk("flg_in3", FLG, 8'h08);
    do_rd_chk("flg_in3_again", FLG, 8'h00);

    // Interrupt on input 3, cleared by W1C.
    do_wr(MSK, 8'h08);
    do_rd_chk("msk_rd", MSK, 8'h08);
    port_in[31:24] = 8'h00;
    idle(3);
    check("irq_before", 64'(irq), 64'd0);
    idle(1);
    check("irq_set", 64'(irq), 64'd1);
    do_wr(FLG, 8'h08);
    idle(1);
    check("irq_cleared", 64'(irq), 64'd0);

    // Set-wins: input 5 flag sets on the same edge as a FLG read.
    port_in[47:40] = 8'h55;
    idle(2);
    do_rd_chk("collide_rd", FLG, 8'h00);
    do_rd_chk("collide_after", FLG, 8'h20);

    // Same-cycle write and read of one address returns the old value.
    bus.addr = AW'(2); bus.wdata = 8'h99; bus.wr = 1'b1; bus.rd = 1'b1;
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b0;
    check("wr_rd_old", 64'(bus.rdata), 64'h3C);
    check("wr_rd_new", 64'(port_out[23:16]), 64'h99);

    // Arm irq, then reset one cycle after a read, then reset during a read.
    do_wr(MSK, 8'hFF);
    port_in[47:40] = 8'h00;
    idle(4);
    check("irq_armed", 64'(irq), 64'd1);
    bus.addr = AW'(2); bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("midrd_rvalid", 64'(bus.rvalid), 64'd0);
    check("midrd_port_out", 64'(port_out), 64'd0);
    check("midrd_irq", 64'(irq), 64'd0);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0; reset = 1'b0;
    check("rd_in_reset_rvalid", 64'(bus.rvalid), 64'd0);
    do_rd_chk("midrd_flg", FLG, 8'h00);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset = (r < 2);
      if ($urandom_range(0, 99) < 15)
        port_in[$urandom_range(0, N_IN-1)*W +: W] = W'($urandom);
      if ($urandom_range(0, 1) == 1) bus.addr = AW'($urandom_range(0, MSK));
      else                           bus.addr = AW'($urandom);
      bus.wdata = W'($urandom);
      bus.wr    = ($urandom_range(0, 2) == 0);
      bus.rd    = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    reset = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0;
    idle(3);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/yasac_io.md
# yasac_io

Parametrised I/O port controller for the next-generation YASAC processor. It replaces the fixed bank of eight 8-bit output and eight 8-bit input ports with a bank of configurable port count and width, addressed through a registered read/write bus from the data unit. It adds two features the fixed bank lacks:

- 2-flop input synchronisation.
- Per-input change-detect flags with a maskable interrupt request.

## Interface
Parameters:
- `W`, 8: port data width.
- `N_OUT`, 8: number of output ports.
- `N_IN`, 8: number of input ports. Must satisfy `N_IN <= W`.
- `AW`, 5: address width. Must satisfy `2**AW >= N_OUT + N_IN + 2`.

Ports:
- `clk`  in  1  clock, rising edge. One clock domain.
- `reset`  in  1  reset, synchronous, active-high.
- `addr`  in  AW  register address.
- `wdata`  in  W  write data.
- `wr`  in  1  write strobe, single cycle.
- `rd`  in  1  read strobe, single cycle.
- `rdata`  out  W  read data, registered.
- `rvalid`  out  1  `rdata` valid, one-cycle pulse.
- `port_out`  out  N_OUT*W  output ports. Port k occupies bits [k*W +: W].
- `port_in`  in  N_IN*W  input ports, asynchronous to `clk`. Same packing as `port_out`.
- `irq`  out  1  interrupt request, registered.

## Operation
Address map:
- `0 .. N_OUT-1`: output registers. Read/write.
- `N_OUT .. N_OUT+N_IN-1`: synchronised input values. Read-only; writes are ignored.
- `FLG = N_OUT+N_IN`: change flags, bit i for input i.
  - Read returns the flags and clears every bit that was read as 1.
  - Write is write-1-to-clear.
- `MSK = FLG+1`: interrupt mask, bits [N_IN-1:0]. Read/write.
- Any other address: writes are ignored; reads return 0 with `rvalid` asserted.

Input path, per port:
- `sync1 <= port_in`, then `sync2 <= sync1`, then `prev <= sync2`.
- Change is detected when `sync2 != prev`. On detection, the port's flag is set.
- Warm-up counter (2 bits): reset to 0, saturating increment to 3. Change detection is enabled only when the counter is 3. This suppresses spurious flags while the synchroniser pipeline fills after reset.

Interrupt: `irq <= |(flags & mask)`.

Conflict rules:
- Flag set and flag clear (read-clear or W1C) in the same cycle: set wins, flag stays 1.
- `wr` and `rd` on the same cycle and same address: `rdata` returns the pre-write value; the write takes effect.
- Unused upper flag and mask bits (i ≥ N_IN) read as 0.

## Timing
Reset values:
- `port_out` = 0, `rdata` = 0, `rvalid` = 0, `irq` = 0.
- flags = 0, mask = 0, sync1/sync2/prev = 0, warm-up counter = 0.

Bus timing:
- Write: effective at the `clk` edge where `wr` is sampled. `port_out` changes on that same edge.
- Read: `rd` sampled at edge n, so `rdata` and `rvalid` are valid after edge n. Latency is 1 cycle. `rvalid` falls after edge n+1 unless `rd` is held high.
- `rd` held high for consecutive cycles: one result is returned per cycle.

Input timing:
- Input change to visibility in the input register: 2 edges.
- Input change to flag set: 3 edges.
- Flag set to `irq`: 1 edge.

Reset asserted mid-operation: a pending read is dropped and `rvalid` is 0 on the next cycle. All state returns to its reset value on that edge.

After reset releases:
- Flags cannot set before the 4th edge.
- A constant non-zero `port_in` present through reset never sets a flag.

## Structure
- Shared defines file `yasac_io_defs`:
  - Address-offset localparams `FLG_OFS` and `MSK_OFS`, expressed relative to `N_OUT + N_IN`.
  - Default values of `W`, `N_OUT` and `N_IN`.
- One sub-module, `yasac_io_sync`, parameter `W`. Ports: `clk`, `reset`, `en`, `din`, `dout`, `chg`. It holds the 2-flop synchroniser, the `prev` register and the change compare. `yasac_io` instantiates it N_IN times, one per input port, and drives `en` from the shared warm-up counter.
- The top level holds the output registers, the flags, the mask, the read mux and `irq`.

## Test plan
- Reset check: hold `reset` 2 cycles with `port_in` = all 0xA5. Required: all outputs 0, and no flag ever sets. Read FLG after 10 cycles → 0x00.
- Write/read outputs: write 0x3C to addr 2, then `rd` addr 2. Required: `port_out[23:16]` = 0x3C the same edge; `rdata` = 0x3C with `rvalid` = 1 one cycle after `rd`. `rd` addr 31 → `rdata` = 0.
- Change detect: set input 3 from 0x00 to 0x7F. Required: input register reads 0x7F from edge 2; FLG reads 0x08 from edge 3. A second FLG read → 0x00.
- Interrupt: write MSK = 0x08, then toggle input 3. Required: `irq` = 1 one edge after the flag sets. W1C write 0x08 to FLG → `irq` = 0 next edge.
- Set-wins collision: time an input 5 change so its flag sets on the same edge as an FLG read. Required: the read returns 0x00 and FLG = 0x20 afterwards.
- Reset mid-read: assert `reset` on the cycle after `rd`. Required: `rvalid` = 0, and `port_out`, flags and `irq` are 0.
